pulse_rate_meter: RTL and testbench

- Receive-side counterpart of the clock-multiple pulse generators.
- Measures an incoming pulse train against the system clock: counts rising edges of `signal` over a fixed gate window of clock cycles.
- Per window, reports the count and whether it equals the expected multiple; declares lock after consecutive matching windows.
- Used by benches and self-check logic to confirm that a generated pulse train has the intended rate.

---
 rtl/pulse_rate_meter.sv | 144 ++++++++++++++
 tb/tb_pulse_rate_meter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_rate_meter.sv
// Pulse rate meter: counts synchronized rising edges of `signal` over a fixed
// gate window, reports count/match/over per window and lock after a match run.
module pulse_rate_meter #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned EXPECT = 4,
    parameter int unsigned LOCK_N = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             match,
    output logic             over,
    output logic             lock
);

    localparam int unsigned WC_W = $clog2(WINDOW);
    localparam int unsigned MR_W = $clog2(LOCK_N + 1);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXPECT);
    localparam logic [MR_W-1:0]  LOCK_C  = MR_W'(LOCK_N);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, d_q;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [MR_W-1:0]   mr_q, mr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              match_q, match_d;
    logic              over_q, over_d;
    logic              lock_q, lock_d;

    logic              rise;
    logic [CNT_W:0]    sum;
    logic              sum_ovf;
    logic [CNT_W-1:0]  sat_acc;
    logic              win_over;
    logic              win_match;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            d_q     <= 1'b0;
            wc_q    <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            mr_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            over_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= signal;
            s2_q    <= s1_q;
            d_q     <= s2_q;
            wc_q    <= wc_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            mr_q    <= mr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            match_q <= match_d;
            over_q  <= over_d;
            lock_q  <= lock_d;
        end
    end

    // Saturating accumulate; the carry bit of `sum` flags overflow.
    always_comb begin
        rise      = s2_q & ~d_q;
        sum       = {1'b0, acc_q} + {{CNT_W{1'b0}}, rise};
        sum_ovf   = sum[CNT_W];
        sat_acc   = sum_ovf ? '1 : sum[CNT_W-1:0];
        win_over  = ovf_q | sum_ovf;
        win_match = (sat_acc == EXP_C) && !win_over;
    end

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        mr_d    = mr_q;
        count_d = count_q;
        valid_d = 1'b0;
        match_d = match_q;
        over_d  = over_q;
        lock_d  = lock_q;

        case (state_q)
            IDLE: begin
                wc_d  = '0;
                acc_d = '0;
                ovf_d = 1'b0;
                if (enable) state_d = MEASURE;
            end
            MEASURE: begin
                if (!enable) begin
                    // Abort discards the partial window and the match run.
                    state_d = IDLE;
                    wc_d    = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    mr_d    = '0;
                    lock_d  = 1'b0;
                end else if (wc_q == WC_LAST) begin
                    count_d = sat_acc;
                    over_d  = win_over;
                    match_d = win_match;
                    valid_d = 1'b1;
                    if (!win_match)          mr_d = '0;
                    else if (mr_q != LOCK_C) mr_d = mr_q + 1'b1;
                    lock_d  = (mr_d == LOCK_C);
                    wc_d    = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    acc_d = sat_acc;
                    ovf_d = win_over;
                    wc_d  = wc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count = count_q;
    assign valid = valid_q;
    assign match = match_q;
    assign over  = over_q;
    assign lock  = lock_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Randomized bench for pulse_rate_meter: two instances (CNT_W=8 and CNT_W=3)
// checked each cycle against a window-sum model built from the sampled input history.
module tb_pulse_rate_meter;

    localparam int W     = 16;
    localparam int EXP   = 4;
    localparam int LN    = 3;
    localparam int MAXC  = 20000;

    logic       clock = 1'b0;
    logic       reset, signal, enable;
    logic [7:0] count8;
    logic [2:0] count3;
    logic       valid8, match8, over8, lock8;
    logic       valid3, match3, over3, lock3;

    always #5 clock = ~clock;

    pulse_rate_meter #(.WINDOW(W), .CNT_W(8), .EXPECT(EXP), .LOCK_N(LN)) dut8 (
        .clock(clock), .reset(reset), .signal(signal), .enable(enable),
        .count(count8), .valid(valid8), .match(match8), .over(over8), .lock(lock8)
    );

    pulse_rate_meter #(.WINDOW(W), .CNT_W(3), .EXPECT(EXP), .LOCK_N(LN)) dut3 (
        .clock(clock), .reset(reset), .signal(signal), .enable(enable),
        .count(count3), .valid(valid3), .match(match3), .over(over3), .lock(lock3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: samp[n] is `signal` as seen at posedge n; an edge is counted at
    // posedge n when the input went 0->1 between samples n-3 and n-2.
    bit samp[0:MAXC];
    int cyc = 3;
    bit started = 1'b0;
    int cmax[2] = '{255, 7};
    int m_st[2], m_ws[2], m_mr[2], m_count[2];
    bit m_valid[2], m_match[2], m_over[2], m_lock[2];

    function automatic int edges_in(input int a, input int b);
        int s = 0;
        for (int n = a; n <= b; n++)
            if (samp[n-2] && !samp[n-3]) s++;
        return s;
    endfunction

    always @(posedge clock) begin
        int raw;
        if (cyc < MAXC) cyc++;
        if (!reset) begin
            samp[cyc] = 1'b0; samp[cyc-1] = 1'b0; samp[cyc-2] = 1'b0;
            started = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_mr[k] = 0; m_count[k] = 0;
                m_valid[k] = 0; m_match[k] = 0; m_over[k] = 0; m_lock[k] = 0;
            end
        end else begin
            samp[cyc] = signal;
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 0;
                if (m_st[k] == 0) begin
                    if (enable) begin m_st[k] = 1; m_ws[k] = cyc + 1; end
                end else if (!enable) begin
                    m_st[k] = 0; m_lock[k] = 0; m_mr[k] = 0;
                end else if (cyc == m_ws[k] + W - 1) begin
                    raw        = edges_in(m_ws[k], cyc);
                    m_over[k]  = raw > cmax[k];
                    m_count[k] = m_over[k] ? cmax[k] : raw;
                    m_match[k] = !m_over[k] && m_count[k] == EXP;
                    m_mr[k]    = m_match[k] ? ((m_mr[k] < LN) ? m_mr[k] + 1 : LN) : 0;
                    m_lock[k]  = m_mr[k] == LN;
                    m_valid[k] = 1;
                    m_ws[k]    = cyc + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("count8", count8, m_count[0]);
            chk("valid8", valid8, m_valid[0]);
            chk("match8", match8, m_match[0]);
            chk("over8",  over8,  m_over[0]);
            chk("lock8",  lock8,  m_lock[0]);
            chk("count3", count3, m_count[1]);
            chk("valid3", valid3, m_valid[1]);
            chk("match3", match3, m_match[1]);
            chk("over3",  over3,  m_over[1]);
            chk("lock3",  lock3,  m_lock[1]);
        end
    end

    // Signal generator: 0 = hold lvl, 1 = toggle every hp clocks, 2 = random.
    int mode = 0, hp = 2, lvl = 0;
    initial begin
        int ph = 0;
        signal = 1'b0;
        forever begin
            @(negedge clock);
            case (mode)
                0: signal = lvl[0];
                1: if (ph >= hp - 1) begin signal = ~signal; ph = 0; end else ph++;
                default: signal = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic wait_valid(input int maxc, output int took);
        took = 0;
        do begin
            @(negedge clock);
            took++;
        end while (!valid8 && took < maxc);
        if (!valid8) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int t, total, nv;
        reset = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_count", count8, 0);
        chk("rst_lock", lock8, 0);
        chk("rst_valid", valid8, 0);

        reset = 1'b1; mode = 1; hp = 2;
        repeat (4) @(negedge clock);
        enable = 1'b1;
        wait_valid(40, t);
        chk("p4_count", count8, 4);
        chk("p4_model_count", m_count[0], 4);
        chk("p4_match", match8, 1);
        chk("p4_over", over8, 0);
        chk("p4_lock1", lock8, 0);
        wait_valid(40, t);
        chk("p4_lock2", lock8, 0);
        wait_valid(40, t);
        chk("p4_lock3", lock8, 1);
        chk("p4_model_lock3", m_lock[0], 1);

        hp = 4;
        repeat (3) wait_valid(40, t);
        chk("p8_count", count8, 2);
        chk("p8_model_count", m_count[0], 2);
        chk("p8_match", match8, 0);
        chk("p8_lock", lock8, 0);

        hp = 2;
        repeat (5) wait_valid(40, t);
        chk("p4b_count", count8, 4);
        chk("p4b_lock", lock8, 1);

        mode = 0; lvl = 1;
        repeat (3) wait_valid(40, t);
        chk("hold1_count", count8, 0);
        chk("hold1_over", over8, 0);
        chk("hold1_match", match8, 0);
        lvl = 0;
        repeat (3) wait_valid(40, t);
        chk("hold0_count", count8, 0);
        lvl = 1;
        total = 0;
        for (int i = 0; i < 3; i++) begin
            wait_valid(40, t);
            total += count8;
        end
        chk("step_total", total, 1);

        mode = 1; hp = 1;
        repeat (2) wait_valid(40, t);
        chk("fast_count3", count3, 7);
        chk("fast_over3", over3, 1);
        chk("fast_match3", match3, 0);
        chk("fast_count8", count8, 8);
        chk("fast_model_count3", m_count[1], 7);

        hp = 2;
        repeat (4) wait_valid(40, t);
        chk("pre_abort_lock", lock8, 1);
        repeat (5) @(negedge clock);
        enable = 1'b0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (valid8) nv++;
        end
        chk("abort_no_valid", nv, 0);
        chk("abort_lock", lock8, 0);
        chk("abort_count", count8, 4);
        enable = 1'b1;
        wait_valid(40, t);
        chk("reen_latency", t, W + 1);
        repeat (2) wait_valid(40, t);
        chk("reen_lock", lock8, 1);

        repeat (6) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mrst_count", count8, 0);
        chk("mrst_lock", lock8, 0);
        chk("mrst_match", match8, 0);
        reset = 1'b1;
        wait_valid(40, t);
        chk("mrst_latency", t, W + 1);
        chk("mrst_lock_after", lock8, 0);

        for (int seg = 0; seg < 60; seg++) begin
            mode   = $urandom_range(0, 2);
            hp     = $urandom_range(1, 6);
            lvl    = $urandom_range(0, 1);
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
            end
            repeat ($urandom_range(20, 80)) @(negedge clock);
        end

        repeat (4) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
